// File: rtl/fifo_sync_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_cfg_if
// Brief    : Producer/consumer bundle for the single-clock configurable FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_sync_cfg_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             flush;
    logic             wrt_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, wrt_en, data_in, rd_en, err_clr,
        input  data_out, valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wrt_en, data_in, rd_en, err_clr,
        output data_out, valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/fifo_sync_cfg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_cfg
// Brief    : Single-clock FIFO, any depth >= 2, level flags, optional FWFT.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_cfg #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fifo_sync_cfg_if.slave   bus
);
    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [CW-1:0]      c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0]      c_af       = CW'(AF_THRESH);
    localparam logic [CW-1:0]      c_ae       = CW'(AE_THRESH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [CW-1:0]      r_count;
    logic               r_empty;
    logic               r_full;
    logic               r_aempty;
    logic               r_afull;
    logic               r_ovf;
    logic               r_udf;

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_ovf_set;
    logic               w_udf_set;
    logic [CW-1:0]      w_count_nxt;

    function automatic logic [c_ptr_w-1:0] f_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + c_ptr_w'(1);
    endfunction

    // Flush masks both requests, so it can never raise an error flag.
    always_comb begin
        w_wr_ok     = bus.wrt_en & ~r_full  & ~bus.flush;
        w_rd_ok     = bus.rd_en  & ~r_empty & ~bus.flush;
        w_ovf_set   = bus.wrt_en &  r_full  & ~bus.flush;
        w_udf_set   = bus.rd_en  &  r_empty & ~bus.flush;
        w_count_nxt = r_count;
        if (bus.flush)
            w_count_nxt = '0;
        else if (w_wr_ok && !w_rd_ok)
            w_count_nxt = r_count + CW'(1);
        else if (w_rd_ok && !w_wr_ok)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (bus.flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_wr_ok) r_wptr <= f_inc(r_wptr);
                if (w_rd_ok) r_rptr <= f_inc(r_rptr);
            end
            // Flags derive from the next count so they change on the same edge.
            r_count  <= w_count_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == c_depth);
            r_aempty <= (w_count_nxt <= c_ae);
            r_afull  <= (w_count_nxt >= c_af);
            if (w_ovf_set)        r_ovf <= 1'b1;
            else if (bus.err_clr) r_ovf <= 1'b0;
            if (w_udf_set)        r_udf <= 1'b1;
            else if (bus.err_clr) r_udf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Storage is not reset, so the head word is masked while empty.
            assign bus.data_out = r_empty ? '0 : r_mem[r_rptr];
            assign bus.valid    = ~r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_ok;
                    if (w_rd_ok) r_dout <= r_mem[r_rptr];
                end
            end

            assign bus.data_out = r_dout;
            assign bus.valid    = r_valid;
        end
    endgenerate

    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_aempty;
    assign bus.almost_full  = r_afull;
    assign bus.count        = r_count;
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_udf;
endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_cfg
// Brief    : Directed scoreboard bench for three fifo_sync_cfg configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_cfg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fifo_sync_cfg_if #(.WIDTH(8), .DEPTH(5))  b5  ();
    fifo_sync_cfg_if #(.WIDTH(8), .DEPTH(16)) b16 ();
    fifo_sync_cfg_if #(.WIDTH(8), .DEPTH(4))  bfw ();

    fifo_sync_cfg #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0))
        u_d5  (.clk(clk), .rst_n(rst_n), .bus(b5));
    fifo_sync_cfg #(.WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0))
        u_d16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    fifo_sync_cfg #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1))
        u_fw  (.clk(clk), .rst_n(rst_n), .bus(bfw));

    // Reference model state: index 0 = depth-5 FIFO, index 1 = depth-16 FIFO.
    logic [7:0] q5[$];
    logic [7:0] q16[$];
    int         mcnt [2];
    logic [7:0] mlast [2];
    bit         movf [2];
    bit         mudf [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        q5.delete();
        q16.delete();
        for (int i = 0; i < 2; i++) begin
            mcnt[i] = 0; mlast[i] = '0; movf[i] = 0; mudf[i] = 0;
        end
    endtask

    task automatic step(input int s, input bit wr, input logic [7:0] din,
                        input bit rd, input bit fl, input bit ec);
        int         depth, af, ae;
        bit         mwr, mrd, exp_valid;
        string      p;
        logic [31:0] o_cnt, o_val, o_dat, o_emp, o_ful, o_ae, o_af, o_ovf, o_udf;
        depth = (s == 0) ? 5 : 16;
        af    = (s == 0) ? 4 : 12;
        ae    = (s == 0) ? 1 : 2;
        p     = (s == 0) ? "d5" : "d16";
        mwr   = wr && !fl && (mcnt[s] != depth);
        mrd   = rd && !fl && (mcnt[s] != 0);
        if (wr && !fl && mcnt[s] == depth) movf[s] = 1;
        else if (ec)                       movf[s] = 0;
        if (rd && !fl && mcnt[s] == 0)     mudf[s] = 1;
        else if (ec)                       mudf[s] = 0;
        if (s == 0) begin
            b5.wrt_en = wr; b5.data_in = din; b5.rd_en = rd; b5.flush = fl; b5.err_clr = ec;
        end else begin
            b16.wrt_en = wr; b16.data_in = din; b16.rd_en = rd; b16.flush = fl; b16.err_clr = ec;
        end
        tick();
        if (mrd) mlast[s] = (s == 0) ? q5.pop_front() : q16.pop_front();
        if (mwr) begin
            if (s == 0) q5.push_back(din); else q16.push_back(din);
        end
        exp_valid = mrd;
        mcnt[s] = fl ? 0 : mcnt[s] + int'(mwr) - int'(mrd);
        if (fl) begin
            if (s == 0) q5.delete(); else q16.delete();
        end
        if (s == 0) begin
            o_cnt = 32'(b5.count); o_val = 32'(b5.valid); o_dat = 32'(b5.data_out);
            o_emp = 32'(b5.empty); o_ful = 32'(b5.full); o_ae = 32'(b5.almost_empty);
            o_af = 32'(b5.almost_full); o_ovf = 32'(b5.overflow); o_udf = 32'(b5.underflow);
        end else begin
            o_cnt = 32'(b16.count); o_val = 32'(b16.valid); o_dat = 32'(b16.data_out);
            o_emp = 32'(b16.empty); o_ful = 32'(b16.full); o_ae = 32'(b16.almost_empty);
            o_af = 32'(b16.almost_full); o_ovf = 32'(b16.overflow); o_udf = 32'(b16.underflow);
        end
        chk({p, "_count"}, o_cnt, 32'(mcnt[s]));
        chk({p, "_valid"}, o_val, 32'(exp_valid));
        chk({p, "_data_out"}, o_dat, 32'(mlast[s]));
        chk({p, "_empty"}, o_emp, 32'(mcnt[s] == 0));
        chk({p, "_full"}, o_ful, 32'(mcnt[s] == depth));
        chk({p, "_almost_empty"}, o_ae, 32'(mcnt[s] <= ae));
        chk({p, "_almost_full"}, o_af, 32'(mcnt[s] >= af));
        chk({p, "_overflow"}, o_ovf, 32'(movf[s]));
        chk({p, "_underflow"}, o_udf, 32'(mudf[s]));
    endtask

    initial begin
        b5.wrt_en = 0;  b5.data_in = '0;  b5.rd_en = 0;  b5.flush = 0;  b5.err_clr = 0;
        b16.wrt_en = 0; b16.data_in = '0; b16.rd_en = 0; b16.flush = 0; b16.err_clr = 0;
        bfw.wrt_en = 0; bfw.data_in = '0; bfw.rd_en = 0; bfw.flush = 0; bfw.err_clr = 0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset / idle state of the depth-16 instance.
        chk("rst_empty", 32'(b16.empty), 32'd1);
        chk("rst_almost_empty", 32'(b16.almost_empty), 32'd1);
        chk("rst_full", 32'(b16.full), 32'd0);
        chk("rst_almost_full", 32'(b16.almost_full), 32'd0);
        chk("rst_count", 32'(b16.count), 32'd0);
        chk("rst_valid", 32'(b16.valid), 32'd0);
        chk("rst_data_out", 32'(b16.data_out), 32'd0);
        chk("rst_flags", 32'({b16.overflow, b16.underflow}), 32'd0);

        // Depth 5: fill, then seven reads (two past empty).
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);

        // Depth 5: interleaved traffic across the 4->0 pointer wrap.
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h10 + i), 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 8'(8'h20 + i), (i % 3) != 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);

        // Depth 5: simultaneous read/write while full; 0xAA must be dropped.
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0);
        step(0, 1, 8'hAA, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 1);

        // FWFT: word written into empty FIFO is presented one cycle later.
        chk("fw_rst_valid", 32'(bfw.valid), 32'd0);
        bfw.wrt_en = 1; bfw.data_in = 8'h3C;
        tick();
        bfw.wrt_en = 0;
        chk("fw_valid", 32'(bfw.valid), 32'd1);
        chk("fw_data_out", 32'(bfw.data_out), 32'h3C);
        bfw.wrt_en = 1; bfw.data_in = 8'h5A;
        tick();
        bfw.wrt_en = 0; bfw.rd_en = 1;
        tick();
        chk("fw_second_word", 32'(bfw.data_out), 32'h5A);
        chk("fw_second_count", 32'(bfw.count), 32'd1);
        tick();
        bfw.rd_en = 0;
        chk("fw_pop_valid", 32'(bfw.valid), 32'd0);
        chk("fw_pop_empty", 32'(bfw.empty), 32'd1);

        // Depth 16: fill, overflow, drain to 11, flush, refill through AF.
        for (int i = 0; i < 16; i++) step(1, 1, 8'(8'h80 + i), 0, 0, 0);
        step(1, 1, 8'hEE, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h00, 1, 0, 0);
        step(1, 1, 8'hEF, 0, 1, 0);
        for (int i = 0; i < 13; i++) step(1, 1, 8'(8'hC0 + i), 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 1, 0, 0);

        // Asynchronous reset mid-burst, then first word after reset.
        step(0, 1, 8'h61, 0, 0, 0);
        step(0, 1, 8'h62, 0, 0, 0);
        b5.wrt_en = 1; b5.data_in = 8'h63;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(b5.count), 32'd0);
        chk("async_rst_empty", 32'(b5.empty), 32'd1);
        chk("async_rst_data_out", 32'(b5.data_out), 32'd0);
        b5.wrt_en = 0;
        model_reset();
        tick();
        rst_n = 1'b1;
        step(0, 1, 8'h77, 0, 0, 0);
        step(0, 0, 8'h00, 1, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_sync_cfg.md
Name: fifo_sync_cfg

Overview:
- Single-clock, parametrised FIFO for the UART TX/RX data paths.
- Replaces dual-clock buffering wherever producer and consumer share one clock.
- Relative to the dual-clock FIFO it adds: arbitrary (non-power-of-2) depth, fill-level count, programmable almost-full/almost-empty flags, a selectable first-word-fall-through read mode, synchronous flush, and sticky overflow/underflow error flags.
- Storage is an internal register array.

Parameters:
- WIDTH, 8: data word width in bits (>=1).
- DEPTH, 16: number of entries; any integer >=2, not restricted to powers of 2.
- AF_THRESH, 12: almost_full asserts when count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1): count width (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- wrt_en  in  1  write request.
- data_in  in  WIDTH  write data.
- rd_en  in  1  read/pop request.
- data_out  out  WIDTH  read data.
- valid  out  1  data_out holds a valid word.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  CW  current number of stored entries.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- err_clr  in  1  clears overflow/underflow.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - Write and read pointers = 0, count = 0, data_out = 0, valid = 0.
  - empty = 1, full = 0, almost_empty = 1.
  - almost_full = 0 (count 0 is below AF_THRESH, which is >=1).
  - overflow = 0, underflow = 0.
  - Array contents are not reset.
- Acceptance (decided against registered state at the start of the cycle):
  - wr_ok = wrt_en & !full; rd_ok = rd_en & !empty.
  - Rejected writes and reads have no effect except setting the error flags.
- Pointers:
  - Each pointer advances by 1 on an accepted operation and wraps from DEPTH-1 to 0.
  - Full and empty are resolved by count, not by pointer MSB comparison.
- Count:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither occur.
  - All flags are registered and updated in the same cycle as count, so they never lag count.
- Simultaneous events:
  - Full + wrt_en + rd_en: the read is accepted, the write is rejected, overflow is set, and count becomes DEPTH-1.
  - Empty + wrt_en + rd_en: the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- FWFT=0 (standard mode):
  - On rd_ok, data_out <= mem[rptr] and valid <= 1 on the next edge (1-cycle latency).
  - Without rd_ok, valid <= 0 and data_out holds its last value.
  - Write-to-read latency: a word written at edge N can be read with rd_en in cycle N+1 and appears at edge N+2.
- FWFT=1 (first-word-fall-through mode):
  - data_out = mem[rptr] continuously; valid = !empty.
  - rd_en acts as a pop/acknowledge of the presented word.
  - A word written into an empty FIFO appears on data_out with valid=1 one cycle after the write edge.
- Error flags:
  - overflow sets on wrt_en & full; underflow sets on rd_en & empty.
  - Both hold until err_clr.
  - If a set condition and err_clr occur in the same cycle, set wins.
  - flush does not clear the error flags.
- Flush:
  - Has priority over wrt_en and rd_en in the same cycle; both are ignored and raise no error flags.
  - Next state equals reset state except that overflow/underflow are preserved and data_out holds.
- Thresholds: AF_THRESH = DEPTH makes almost_full equal to full; AE_THRESH = 0 makes almost_empty equal to empty.
- Reset mid-burst: all state returns immediately to reset values. The first write after rst_n deassertion lands at address 0.

Test Plan:
- Reset then idle, DEPTH=16 -> empty=1, almost_empty=1, full=0, count=0, valid=0, data_out=0.
- FWFT=0, DEPTH=5 (non-power-of-2): write 0x01..0x05 -> full=1, count=5. Then 7 reads -> data_out 0x01..0x05 one cycle after each rd_en, underflow=1 on read 6, empty=1.
- DEPTH=5 wrap: 3 cycles of interleaved writes/reads, then 12 further writes/reads -> data order preserved across pointer wrap 4->0, count never exceeds 5.
- Full FIFO, wrt_en=rd_en=1 with data_in=0xAA -> count goes 5->4, overflow=1, 0xAA is not stored. Then err_clr with no new violation -> overflow=0.
- FWFT=1, empty FIFO: write 0x3C at edge N -> at N+1 valid=1 and data_out=0x3C. Pulse rd_en -> valid=0, empty=1.
- DEPTH=16, AF=12, AE=2: fill to count 11, flush with wrt_en=1 and overflow previously set -> count=0, empty=1, overflow still 1. Refill to 12 -> almost_full asserts on the edge where count reaches 12.
